// File: rtl/msg_block_packer.sv
// msg_block_packer
//   Packs a stream of narrow payload blocks into NumBlocks-wide words for the
//   downstream dequeue shift register. Each block carries an interleaved
//   message-start control bit at StartBitPos. A partial word is closed by
//   flush_i or an idle timeout and padded with all-zero blocks. A zero block
//   has start bit 0, so downstream alignment never locks onto padding.
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   flush_i       close the current partial word (pad and commit)
//   blk_valid_i   input block valid
//   blk_ready_o   input block ready (assembly buffer not full)
//   blk_data_i    block payload, BlockSize-1 bits
//   blk_start_i   block is the first of a message
//   valid_o       output word valid
//   ready_i       output word ready
//   data_o        packed word, block i at [i*BlockSize +: BlockSize]
//   busy_o        partial word pending or output word held
//
// Optional feature (macro MSG_BLOCK_PACKER_STATS_EN)
//   words_o       wrapping count of output handshakes
//   pad_blocks_o  wrapping count of zero blocks inserted by commits
module msg_block_packer #(
    parameter int unsigned BlockSize     = 8,
    parameter int unsigned NumBlocks     = 8,
    parameter int unsigned StartBitPos   = 0,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           blk_valid_i,
    output logic                           blk_ready_o,
    input  logic [BlockSize-2:0]           blk_data_i,
    input  logic                           blk_start_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [NumBlocks*BlockSize-1:0] data_o,
    output logic                           busy_o
`ifdef MSG_BLOCK_PACKER_STATS_EN
    ,
    output logic [31:0]                    words_o,
    output logic [31:0]                    pad_blocks_o
`endif
);

    localparam int unsigned WordW = NumBlocks * BlockSize;
    localparam int unsigned CntW  = $clog2(NumBlocks + 1);
    localparam int unsigned IdleW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    logic [WordW-1:0]     asm_q;
    logic [WordW-1:0]     asm_d;
    logic [WordW-1:0]     out_q;
    logic [WordW-1:0]     out_d;
    logic [CntW-1:0]      cnt_q;
    logic [CntW-1:0]      cnt_d;
    logic [IdleW-1:0]     idle_q;
    logic                 valid_q;
    logic [BlockSize-1:0] blk_enc;
    logic                 in_hs;
    logic                 out_free;
    logic                 timeout;
    logic                 commit;

    // Payload bits below StartBitPos stay in place; the rest shift up by one
    // to make room for the control bit.
    always_comb begin
        blk_enc = '0;
        for (int unsigned j = 0; j < BlockSize - 1; j++) begin
            if (j < StartBitPos) begin
                blk_enc[j] = blk_data_i[j];
            end else begin
                blk_enc[j+1] = blk_data_i[j];
            end
        end
        blk_enc[StartBitPos] = blk_start_i;
    end

    assign blk_ready_o = (cnt_q != CntW'(NumBlocks));
    assign in_hs       = blk_valid_i & blk_ready_o;
    assign out_free    = ~valid_q | ready_i;
    assign cnt_d       = cnt_q + CntW'(in_hs);
    assign timeout     = (TimeoutCycles != 0) && (idle_q == IdleW'(TimeoutCycles));
    assign commit      = out_free && (cnt_d != '0) &&
                         ((cnt_d == CntW'(NumBlocks)) || flush_i || timeout);

    // asm_d merges this cycle's block; out_d is the commit candidate with
    // every slot at or above the new fill count forced to zero.
    always_comb begin
        asm_d = asm_q;
        out_d = '0;
        for (int unsigned i = 0; i < NumBlocks; i++) begin
            if (in_hs && (cnt_q == CntW'(i))) begin
                asm_d[i*BlockSize +: BlockSize] = blk_enc;
            end
            if (CntW'(i) < cnt_d) begin
                out_d[i*BlockSize +: BlockSize] = asm_d[i*BlockSize +: BlockSize];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asm_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
            valid_q <= 1'b0;
        end else if (commit) begin
            // A commit wins over a concurrent output handshake, keeping
            // valid high with the new word.
            out_q   <= out_d;
            valid_q <= 1'b1;
            asm_q   <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            asm_q <= asm_d;
            cnt_q <= cnt_d;
            if (in_hs || (cnt_q == '0)) begin
                idle_q <= '0;
            end else if (idle_q != IdleW'(TimeoutCycles)) begin
                idle_q <= idle_q + IdleW'(1);
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = out_q;
    assign busy_o  = (cnt_q != '0) | valid_q;

`ifdef MSG_BLOCK_PACKER_STATS_EN
    logic [31:0] words_q;
    logic [31:0] pad_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            words_q <= '0;
            pad_q   <= '0;
        end else begin
            if (valid_q && ready_i) begin
                words_q <= words_q + 32'd1;
            end
            if (commit) begin
                pad_q <= pad_q + (32'(NumBlocks) - 32'(cnt_d));
            end
        end
    end

    assign words_o      = words_q;
    assign pad_blocks_o = pad_q;
`endif

endmodule

// File: tb/tb_msg_block_packer.sv
module tb_msg_block_packer;

    localparam int unsigned BS = 8;
    localparam int unsigned NB = 4;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst, flush, blk_valid, blk_start, ready;
    logic [BS-2:0] blk_data;
    logic          blk_ready, valid, busy;
    logic [NB*BS-1:0] data;

    logic          z_rst, z_flush, z_valid, z_start, z_ready;
    logic [BS-2:0] z_data;
    logic          z_blk_ready, z_vld, z_busy;
    logic [NB*BS-1:0] z_dout;

`ifdef MSG_BLOCK_PACKER_STATS_EN
    logic [31:0] words, pads, z_words, z_pads;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msg_block_packer #(.BlockSize(BS), .NumBlocks(NB), .StartBitPos(0), .TimeoutCycles(TO)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready),
        .blk_data_i(blk_data), .blk_start_i(blk_start),
        .valid_o(valid), .ready_i(ready), .data_o(data), .busy_o(busy)
`ifdef MSG_BLOCK_PACKER_STATS_EN
        , .words_o(words), .pad_blocks_o(pads)
`endif
    );

    msg_block_packer #(.BlockSize(BS), .NumBlocks(NB), .StartBitPos(0), .TimeoutCycles(0)) u_dut_nt (
        .clk_i(clk), .rst_i(z_rst), .flush_i(z_flush),
        .blk_valid_i(z_valid), .blk_ready_o(z_blk_ready),
        .blk_data_i(z_data), .blk_start_i(z_start),
        .valid_o(z_vld), .ready_i(z_ready), .data_o(z_dout), .busy_o(z_busy)
`ifdef MSG_BLOCK_PACKER_STATS_EN
        , .words_o(z_words), .pad_blocks_o(z_pads)
`endif
    );

    // Reference model: pending blocks as a queue, output word as a register.
    logic [BS-1:0]    m_pend[$];
    int               m_idle = 0;
    logic             m_valid = 1'b0;
    logic [NB*BS-1:0] m_data = '0;

    function automatic logic [BS-1:0] enc(input logic [BS-2:0] d, input logic s);
        return {d, s};
    endfunction

    // Advance the model by one cycle using the currently driven inputs,
    // then wait for the clock edge and settle.
    task automatic step();
        logic [BS-1:0]    nxt[$];
        logic             acc, ofree, tmo, com;
        logic [NB*BS-1:0] w;
        if (rst) begin
            m_pend.delete();
            m_idle  = 0;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            acc = blk_valid && (m_pend.size() != NB);
            nxt = m_pend;
            if (acc) nxt.push_back(enc(blk_data, blk_start));
            ofree = !m_valid || ready;
            tmo   = (TO != 0) && (m_idle == TO);
            com   = ofree && (nxt.size() > 0) && ((nxt.size() == NB) || flush || tmo);
            if (com) begin
                w = '0;
                foreach (nxt[k]) w[k*BS +: BS] = nxt[k];
                m_data  = w;
                m_valid = 1'b1;
                m_pend.delete();
                m_idle  = 0;
            end else begin
                if (m_valid && ready) m_valid = 1'b0;
                if (acc || (m_pend.size() == 0)) m_idle = 0;
                else if (m_idle < TO) m_idle++;
                m_pend = nxt;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [BS-2:0] d, input logic s);
        blk_valid = 1'b1;
        blk_data  = d;
        blk_start = s;
        step();
        blk_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; z_rst = 1'b1;
        step();
        step();
        rst = 1'b0; z_rst = 1'b0;
        checks++;
        if ({valid, busy, blk_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_flags got v/b/r=%b exp 001", {valid, busy, blk_ready});
        end
        checks++;
        if (data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", data);
        end
    endtask

    task automatic test_full_word();
        ready = 1'b1;
        send(7'h01, 1'b1);
        send(7'h02, 1'b0);
        send(7'h03, 1'b0);
        checks++;
        if ({valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL full_partial got v/b=%b exp 01", {valid, busy});
        end
        send(7'h04, 1'b0);
        checks++;
        if (valid !== 1'b1 || data !== 32'h08060403) begin
            errors++;
            $display("FAIL full_word got v=%b d=%h exp v=1 d=08060403", valid, data);
        end
        step();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL full_drain got v/b=%b exp 00", {valid, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [BS-2:0]    p[8];
        logic [NB*BS-1:0] w1, w2;
        ready = 1'b0;
        for (int i = 0; i < 8; i++) p[i] = 7'($urandom);
        w1 = {enc(p[3], 0), enc(p[2], 0), enc(p[1], 0), enc(p[0], 1)};
        w2 = {enc(p[7], 0), enc(p[6], 0), enc(p[5], 0), enc(p[4], 1)};
        for (int i = 0; i < 8; i++) send(p[i], (i % 4) == 0);
        checks++;
        if (valid !== 1'b1 || data !== w1 || blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got v=%b d=%h r=%b exp v=1 d=%h r=0", valid, data, blk_ready, w1);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (data !== w1 || blk_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got d=%h r=%b exp d=%h r=0", data, blk_ready, w1);
            end
        end
        ready = 1'b1;
        step();
        checks++;
        if (valid !== 1'b1 || data !== w2 || blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got v=%b d=%h r=%b exp v=1 d=%h r=1", valid, data, blk_ready, w2);
        end
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b exp 0", valid);
        end
    endtask

    task automatic test_flush();
        ready = 1'b1;
        send(7'h7F, 1'b1);
        send(7'h10, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (valid !== 1'b1 || data !== 32'h000020FF) begin
            errors++;
            $display("FAIL flush_word got v=%b d=%h exp v=1 d=000020ff", valid, data);
        end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_empty got v/b=%b exp 00", {valid, busy});
        end
    endtask

    task automatic test_timeout();
        logic seen;
        ready = 1'b1;
        send(7'h05, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early idle=%0d got v=%b exp 0", i + 1, valid);
            end
        end
        step();
        checks++;
        if (valid !== 1'b1 || data !== 32'h0000000B) begin
            errors++;
            $display("FAIL timeout_word got v=%b d=%h exp v=1 d=0000000b", valid, data);
        end
        step();
        // Instance without timeout: one block must sit forever.
        z_ready = 1'b1; z_valid = 1'b1; z_data = 7'h05; z_start = 1'b1;
        @(posedge clk); #1;
        z_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (z_vld) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || z_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_disabled got seen=%b busy=%b exp seen=0 busy=1", seen, z_busy);
        end
    endtask

    task automatic test_flush_with_block();
        logic [BS-2:0]    p[4];
        logic [NB*BS-1:0] w;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) p[i] = 7'($urandom);
        w = {enc(p[3], 0), enc(p[2], 0), enc(p[1], 0), enc(p[0], 1)};
        for (int i = 0; i < 3; i++) send(p[i], i == 0);
        flush = 1'b1;
        send(p[3], 1'b0);
        flush = 1'b0;
        checks++;
        if (valid !== 1'b1 || data !== w) begin
            errors++;
            $display("FAIL flush_blk got v=%b d=%h exp v=1 d=%h", valid, data, w);
        end
        step();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL flush_blk_drain got v/b=%b exp 00", {valid, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [BS-2:0]    p[4];
        logic [NB*BS-1:0] w;
        ready = 1'b1;
        send(7'h55, 1'b1);
        send(7'h2A, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({valid, busy, blk_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_flags got v/b/r=%b exp 001", {valid, busy, blk_ready});
        end
        for (int i = 0; i < 4; i++) p[i] = 7'($urandom);
        w = {enc(p[3], 0), enc(p[2], 1), enc(p[1], 0), enc(p[0], 1)};
        for (int i = 0; i < 4; i++) send(p[i], (i % 2) == 0);
        checks++;
        if (valid !== 1'b1 || data !== w) begin
            errors++;
            $display("FAIL rstmid_word got v=%b d=%h exp v=1 d=%h", valid, data, w);
        end
        // Held output word is dropped by reset.
        ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_held got v/b=%b exp 00", {valid, busy});
        end
    endtask

    task automatic test_random();
        int vprob;
        for (int c = 0; c < 1200; c++) begin
            vprob     = ((c / 150) % 2 == 0) ? 70 : 4;
            blk_valid = ($urandom_range(0, 99) < vprob);
            blk_data  = 7'($urandom);
            blk_start = $urandom_range(0, 3) == 0;
            ready     = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if ({valid, blk_ready, busy} !== {m_valid, m_pend.size() != NB, (m_pend.size() != 0) || m_valid}) begin
                errors++;
                $display("FAIL rand_flags cyc=%0d got v/r/b=%b exp %b", c, {valid, blk_ready, busy},
                         {m_valid, m_pend.size() != NB, (m_pend.size() != 0) || m_valid});
            end
            checks++;
            if (data !== m_data) begin
                errors++;
                $display("FAIL rand_data cyc=%0d got %h exp %h", c, data, m_data);
            end
        end
        blk_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; blk_valid = 1'b0; blk_start = 1'b0; ready = 1'b1; blk_data = '0;
        z_rst = 1'b1; z_flush = 1'b0; z_valid = 1'b0; z_start = 1'b0; z_ready = 1'b1; z_data = '0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush();
        test_timeout();
        test_flush_with_block();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
